// File: rtl/if_stage_unit_if.sv
// Fetch-stage bus: branch redirect and hazard inputs, instruction-memory port,
// and the IF/ID register outputs.
//   master : the fetch unit (drives imem_addr, IF/ID, flush_o, halted, taken_cnt)
//   slave  : the surrounding pipeline / memory (drives pc_src, branch_target,
//            stall, imem_rdata)
interface if_stage_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pc_src;
  logic [31:0]      branch_target;
  logic             stall;
  logic [31:0]      imem_rdata;
  logic [31:0]      imem_addr;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic             flush_o;
  logic             halted;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    input  pc_src, branch_target, stall, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, flush_o, halted, taken_cnt
  );

  modport slave (
    output pc_src, branch_target, stall, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, flush_o, halted, taken_cnt
  );
endinterface

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: holds the PC, addresses instruction memory, registers
// the fetched word into IF/ID, redirects on taken branches and stops on HALT.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : if_stage_unit_if.master (see interface for signal list)
module if_stage_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  if_stage_unit_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_q, state_n;
  logic [31:0]      pc_q, pc_n;
  logic [31:0]      instr_q, instr_n;
  logic [31:0]      pc4_q, pc4_n;
  logic             valid_q, valid_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [31:0]      pc_plus4;

  // PC+4 wraps naturally at 2^32
  assign pc_plus4 = pc_q + 32'd4;

  // State and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      pc4_q   <= pc4_n;
      valid_q <= valid_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state: branch redirect beats halt, halt beats stall, stall beats fetch
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    instr_n = instr_q;
    pc4_n   = pc4_q;
    valid_n = valid_q;
    cnt_n   = cnt_q;

    if (bus.pc_src) begin
      // Redirect also resumes from HALTED: the branch was in flight before HALT
      pc_n    = {bus.branch_target[31:2], 2'b00};
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      state_n = RUN;
      if (cnt_q != {CNT_W{1'b1}}) cnt_n = cnt_q + CNT_W'(1);
    end else if (state_q == HALTED) begin
      valid_n = 1'b0;
    end else if (bus.stall) begin
      // hold everything
    end else if (bus.imem_rdata == HALT_INSTR) begin
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      state_n = HALTED;
    end else begin
      pc_n    = pc_plus4;
      instr_n = bus.imem_rdata;
      pc4_n   = pc_plus4;
      valid_n = 1'b1;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc4   = pc4_q;
  assign bus.ifid_valid = valid_q;
  assign bus.halted     = (state_q == HALTED);
  assign bus.taken_cnt  = cnt_q;
  // Downstream squash must happen on the same edge as the redirect
  assign bus.flush_o    = bus.pc_src;

endmodule

// File: tb/tb_if_stage_unit.sv
module tb_if_stage_unit;

  logic clk;
  logic rst_n;

  if_stage_unit_if #(.CNT_W(16)) b16 ();
  if_stage_unit_if #(.CNT_W(2))  b2  ();

  if_stage_unit #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b16));
  if_stage_unit #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_src;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        chk_pc4;
    logic        e_valid;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int unsigned NV = 15;
  vec_t vecs[NV];

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ps, input logic [31:0] tgt, input logic st,
                              input logic [31:0] rd, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] p4,
                              input logic cp4, input logic v, input logic h,
                              input logic [15:0] c);
    vec_t r;
    r.pc_src = ps; r.tgt = tgt; r.stall = st; r.rdata = rd;
    r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.chk_pc4 = cp4;
    r.e_valid = v; r.e_halt = h; r.e_cnt = c;
    return r;
  endfunction

  task automatic check_regs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] p4, input logic cp4, input logic v,
                            input logic h, input logic [15:0] c);
    chk({tag, ".imem_addr"}, b16.imem_addr, pc);
    chk({tag, ".ifid_instr"}, b16.ifid_instr, ins);
    if (cp4) chk({tag, ".ifid_pc4"}, b16.ifid_pc4, p4);
    chk({tag, ".ifid_valid"}, 32'(b16.ifid_valid), 32'(v));
    chk({tag, ".halted"}, 32'(b16.halted), 32'(h));
    chk({tag, ".taken_cnt"}, 32'(b16.taken_cnt), 32'(c));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //            pc_src tgt           stall rdata          pc            instr         pc4          cp4 v  h  cnt
    vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h11,        32'h4,        32'h11,       32'h4,       1, 1, 0, 0);
    vecs[1]  = mk(1'b0, 32'h0,        1'b0, 32'h22,        32'h8,        32'h22,       32'h8,       1, 1, 0, 0);
    vecs[2]  = mk(1'b0, 32'h0,        1'b1, 32'h33,        32'h8,        32'h22,       32'h8,       1, 1, 0, 0);
    vecs[3]  = mk(1'b0, 32'h0,        1'b1, 32'h33,        32'h8,        32'h22,       32'h8,       1, 1, 0, 0);
    vecs[4]  = mk(1'b0, 32'h0,        1'b0, 32'h33,        32'hC,        32'h33,       32'hC,       1, 1, 0, 0);
    vecs[5]  = mk(1'b1, 32'h103,      1'b1, 32'h44,        32'h100,      32'h0,        32'h0,       0, 0, 0, 1);
    vecs[6]  = mk(1'b0, 32'h0,        1'b0, 32'h55,        32'h104,      32'h55,       32'h104,     1, 1, 0, 1);
    vecs[7]  = mk(1'b1, 32'h20,       1'b0, 32'h56,        32'h20,       32'h0,        32'h0,       0, 0, 0, 2);
    vecs[8]  = mk(1'b0, 32'h0,        1'b0, 32'hFFFF_FFFF, 32'h20,       32'h0,        32'h0,       0, 0, 1, 2);
    vecs[9]  = mk(1'b0, 32'h0,        1'b0, 32'h66,        32'h20,       32'h0,        32'h0,       0, 0, 1, 2);
    vecs[10] = mk(1'b0, 32'h0,        1'b1, 32'h67,        32'h20,       32'h0,        32'h0,       0, 0, 1, 2);
    vecs[11] = mk(1'b1, 32'h40,       1'b0, 32'h68,        32'h40,       32'h0,        32'h0,       0, 0, 0, 3);
    vecs[12] = mk(1'b0, 32'h0,        1'b0, 32'h77,        32'h44,       32'h77,       32'h44,      1, 1, 0, 3);
    vecs[13] = mk(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h78,       32'hFFFF_FFFC, 32'h0,       32'h0,       0, 0, 0, 4);
    vecs[14] = mk(1'b0, 32'h0,        1'b0, 32'h88,        32'h0,        32'h88,       32'h0,       1, 1, 0, 4);

    b16.pc_src = 1'b0; b16.branch_target = 32'h0; b16.stall = 1'b0; b16.imem_rdata = 32'h0;
    b2.pc_src  = 1'b0; b2.branch_target  = 32'h0; b2.stall  = 1'b0; b2.imem_rdata  = 32'h0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("reset.cnt2", 32'(b2.taken_cnt), 32'd0);
    rst_n = 1'b1;

    // Main table: inputs set just after an edge, registered results checked after the next
    for (int i = 0; i < int'(NV); i++) begin
      b16.pc_src        = vecs[i].pc_src;
      b16.branch_target = vecs[i].tgt;
      b16.stall         = vecs[i].stall;
      b16.imem_rdata    = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d.flush_o", i), 32'(b16.flush_o), 32'(vecs[i].pc_src));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                 vecs[i].chk_pc4, vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 4; i++) begin
      b2.pc_src        = 1'b1;
      b2.branch_target = 32'h200;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.taken_cnt", i), 32'(b2.taken_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    b2.pc_src = 1'b0;

    // Get to pc=0x80 with a valid IF/ID entry, then reset without a clock edge
    b16.pc_src = 1'b1; b16.branch_target = 32'h7C; b16.stall = 1'b0;
    @(posedge clk);
    #1;
    b16.pc_src = 1'b0; b16.imem_rdata = 32'h99;
    @(posedge clk);
    #1;
    check_regs("pre_rst", 32'h80, 32'h99, 32'h80, 1'b1, 1'b1, 1'b0, 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async_rst", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("async_rst.cnt2", 32'(b2.taken_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b16.imem_rdata = 32'hAB;
    @(posedge clk);
    #1;
    check_regs("post_rst", 32'h4, 32'hAB, 32'h4, 1'b1, 1'b1, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
